// File: rtl/mux_nway_buffered_pkg.sv
// mux_nway_buffered_pkg
// Shared definitions for the buffered N-way mux: the occupancy state encoding,
// the bad-select counter width and its saturation value, and a saturating
// increment helper.
package mux_nway_buffered_pkg;

    // Buffer occupancy; the numeric values match the entry count held.
    typedef enum logic [1:0] {
        StEmpty = 2'd0,
        StHalf  = 2'd1,
        StFull  = 2'd2
    } buf_state_e;

    localparam int unsigned CntW = 8;
    localparam logic [CntW-1:0] CntMax = {CntW{1'b1}};

    // Increment that sticks at CntMax instead of wrapping.
    function automatic logic [CntW-1:0] sat_inc(input logic [CntW-1:0] val);
        if (val == CntMax) begin
            return val;
        end
        return val + 1'b1;
    endfunction

endpackage

// File: rtl/mux_nway_sel.sv
// mux_nway_sel
// Purely combinational N-way selector with range check. A select value at or
// beyond NUM_IN yields DEFAULT_VAL and raises sel_err.
//
// Ports:
//   in_data  - NUM_IN flattened sources, source i at [i*WIDTH +: WIDTH]
//   in_sel   - source index
//   sel_data - selected source (or DEFAULT_VAL when out of range)
//   sel_err  - 1 when in_sel >= NUM_IN
module mux_nway_sel #(
    parameter int unsigned         WIDTH       = 32,
    parameter int unsigned         NUM_IN      = 3,
    parameter int unsigned         SEL_W       = 2,
    parameter logic [WIDTH-1:0]    DEFAULT_VAL = '0
) (
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]        in_sel,
    output logic [WIDTH-1:0]        sel_data,
    output logic                    sel_err
);

    // Compare against each legal index rather than indexing by in_sel, so an
    // out-of-range select never forms an out-of-bounds slice.
    always_comb begin
        sel_data = DEFAULT_VAL;
        sel_err  = 1'b1;
        for (int unsigned i = 0; i < NUM_IN; i++) begin
            if (in_sel == SEL_W'(i)) begin
                sel_data = in_data[i*WIDTH +: WIDTH];
                sel_err  = 1'b0;
            end
        end
    end

endmodule

// File: rtl/mux_nway_buffered.sv
// mux_nway_buffered
// N-way mux feeding a two-entry FIFO with valid/ready handshakes on both
// sides. The selected value (or DEFAULT_VAL on an out-of-range select) is
// registered on push and presented from the head register one cycle later.
// Out-of-range selects that are accepted are counted in a saturating counter.
//
// Ports:
//   clk         - clock, rising edge
//   reset       - synchronous active-high reset
//   in_data     - NUM_IN flattened sources
//   in_sel      - source index, sampled with in_data
//   in_valid    - offer on the input side
//   in_ready    - block can accept an offer this cycle
//   out_data    - head entry data
//   out_err     - head entry came from an out-of-range select
//   out_valid   - head entry is valid
//   out_ready   - consumer takes the head entry this cycle
//   bad_sel_cnt - accepted out-of-range selects, saturating
module mux_nway_buffered
    import mux_nway_buffered_pkg::*;
#(
    parameter int unsigned         WIDTH       = 32,
    parameter int unsigned         NUM_IN      = 3,
    parameter int unsigned         SEL_W       = 2,
    parameter logic [WIDTH-1:0]    DEFAULT_VAL = '0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]        in_sel,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic                    out_err,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [CntW-1:0]         bad_sel_cnt
);

    buf_state_e       state_q, state_d;
    logic [WIDTH-1:0] head_data_q, head_data_d;
    logic             head_err_q, head_err_d;
    logic [WIDTH-1:0] tail_data_q, tail_data_d;
    logic             tail_err_q, tail_err_d;
    logic [CntW-1:0]  cnt_q, cnt_d;

    logic [WIDTH-1:0] sel_data;
    logic             sel_err;
    logic             push;
    logic             pop;

    mux_nway_sel #(
        .WIDTH       (WIDTH),
        .NUM_IN      (NUM_IN),
        .SEL_W       (SEL_W),
        .DEFAULT_VAL (DEFAULT_VAL)
    ) u_sel (
        .in_data  (in_data),
        .in_sel   (in_sel),
        .sel_data (sel_data),
        .sel_err  (sel_err)
    );

    // Handshake status comes only from registered state (and reset), so there
    // is no combinational path from out_ready to in_ready.
    assign in_ready  = (state_q != StFull) && !reset;
    assign out_valid = (state_q != StEmpty);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    assign out_data    = head_data_q;
    // Head data is kept after the last pop; the error flag is masked instead.
    assign out_err     = head_err_q && out_valid;
    assign bad_sel_cnt = cnt_q;

    always_comb begin
        state_d     = state_q;
        head_data_d = head_data_q;
        head_err_d  = head_err_q;
        tail_data_d = tail_data_q;
        tail_err_d  = tail_err_q;
        cnt_d       = cnt_q;

        if (push && sel_err) begin
            cnt_d = sat_inc(cnt_q);
        end

        unique case (state_q)
            StEmpty: begin
                if (push) begin
                    head_data_d = sel_data;
                    head_err_d  = sel_err;
                    state_d     = StHalf;
                end
            end
            StHalf: begin
                if (push && pop) begin
                    // Head is consumed this edge, so the new entry becomes head.
                    head_data_d = sel_data;
                    head_err_d  = sel_err;
                end else if (push) begin
                    tail_data_d = sel_data;
                    tail_err_d  = sel_err;
                    state_d     = StFull;
                end else if (pop) begin
                    state_d = StEmpty;
                end
            end
            StFull: begin
                // in_ready is low here, so push cannot occur.
                if (pop) begin
                    head_data_d = tail_data_q;
                    head_err_d  = tail_err_q;
                    state_d     = StHalf;
                end
            end
            default: begin
                state_d = StEmpty;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StEmpty;
            head_data_q <= '0;
            head_err_q  <= 1'b0;
            tail_data_q <= '0;
            tail_err_q  <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            head_data_q <= head_data_d;
            head_err_q  <= head_err_d;
            tail_data_q <= tail_data_d;
            tail_err_q  <= tail_err_d;
            cnt_q       <= cnt_d;
        end
    end

endmodule

// File: tb/tb_mux_nway_buffered.sv
// tb_mux_nway_buffered
// Directed bench for mux_nway_buffered at WIDTH=32, NUM_IN=3, SEL_W=2,
// DEFAULT_VAL=0. Inputs change 1ns after a rising edge; outputs are checked
// at that same point, well away from the next edge.
module tb_mux_nway_buffered;

    localparam int unsigned WIDTH  = 32;
    localparam int unsigned NUM_IN = 3;
    localparam int unsigned SEL_W  = 2;

    logic                    clk;
    logic                    reset;
    logic [NUM_IN*WIDTH-1:0] in_data;
    logic [SEL_W-1:0]        in_sel;
    logic                    in_valid;
    logic                    in_ready;
    logic [WIDTH-1:0]        out_data;
    logic                    out_err;
    logic                    out_valid;
    logic                    out_ready;
    logic [7:0]              bad_sel_cnt;

    int vectors;
    int miscompares;

    mux_nway_buffered #(
        .WIDTH       (WIDTH),
        .NUM_IN      (NUM_IN),
        .SEL_W       (SEL_W),
        .DEFAULT_VAL ('0)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .in_data     (in_data),
        .in_sel      (in_sel),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .out_data    (out_data),
        .out_err     (out_err),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .bad_sel_cnt (bad_sel_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge, then settle 1ns before driving/checking.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b1;
        in_data     = {32'h33333333, 32'h22222222, 32'h11111111};
        in_sel      = '0;
        in_valid    = 1'b0;
        out_ready   = 1'b0;

        // Reset state
        tick();
        tick();
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_data", out_data, 32'h0);
        check("rst_out_err", 32'(out_err), 32'd0);
        check("rst_cnt", 32'(bad_sel_cnt), 32'd0);
        reset = 1'b0;
        #1;
        check("rel_in_ready", 32'(in_ready), 32'd1);

        // Single push, sel=1, one-cycle latency then drained
        in_sel    = 2'd1;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        check("s1_out_valid", 32'(out_valid), 32'd1);
        check("s1_out_data", out_data, 32'h22222222);
        check("s1_out_err", 32'(out_err), 32'd0);
        tick();
        check("s1_drain_valid", 32'(out_valid), 32'd0);
        check("s1_hold_data", out_data, 32'h22222222);
        check("s1_drain_err", 32'(out_err), 32'd0);

        // Out-of-range select
        in_sel   = 2'd3;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check("bad_out_data", out_data, 32'h0);
        check("bad_out_err", 32'(out_err), 32'd1);
        check("bad_cnt1", 32'(bad_sel_cnt), 32'd1);
        tick();
        check("bad_drain_err", 32'(out_err), 32'd0);

        // 300 more bad pushes, streaming through HALF: counter saturates
        in_valid = 1'b1;
        repeat (300) @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("sat_cnt", 32'(bad_sel_cnt), 32'd255);
        check("sat_out_err", 32'(out_err), 32'd1);
        tick();
        check("sat_drain_valid", 32'(out_valid), 32'd0);

        // Fill to FULL, ignored third offer, ordered drain
        out_ready = 1'b0;
        in_sel    = 2'd0;
        in_valid  = 1'b1;
        tick();
        in_sel = 2'd2;
        tick();
        check("full_in_ready", 32'(in_ready), 32'd0);
        check("full_head", out_data, 32'h11111111);
        in_sel = 2'd1;  // third offer, must be ignored
        tick();
        in_valid = 1'b0;
        check("full_hold_head", out_data, 32'h11111111);
        check("full_hold_ready", 32'(in_ready), 32'd0);
        out_ready = 1'b1;
        tick();
        check("pop1_data", out_data, 32'h33333333);
        check("pop1_valid", 32'(out_valid), 32'd1);
        check("pop1_in_ready", 32'(in_ready), 32'd1);
        tick();
        check("pop2_valid", 32'(out_valid), 32'd0);

        // HALF with simultaneous push and pop
        out_ready = 1'b0;
        in_sel    = 2'd0;
        in_valid  = 1'b1;
        tick();
        in_sel    = 2'd2;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        check("pp_valid", 32'(out_valid), 32'd1);
        check("pp_data", out_data, 32'h33333333);
        check("pp_in_ready", 32'(in_ready), 32'd1);
        tick();
        check("pp_drain_valid", 32'(out_valid), 32'd0);

        // Reset while FULL, with offer and pop pending on that edge
        out_ready = 1'b0;
        in_sel    = 2'd0;
        in_valid  = 1'b1;
        tick();
        in_sel = 2'd1;
        tick();
        check("pre_rst_in_ready", 32'(in_ready), 32'd0);
        reset     = 1'b1;
        out_ready = 1'b1;
        tick();
        check("mrst_out_valid", 32'(out_valid), 32'd0);
        check("mrst_out_data", out_data, 32'h0);
        check("mrst_cnt", 32'(bad_sel_cnt), 32'd0);
        check("mrst_in_ready", 32'(in_ready), 32'd0);
        in_valid = 1'b0;
        reset    = 1'b0;
        #1;
        check("mrst_rel_ready", 32'(in_ready), 32'd1);

        // Normal operation resumes after reset
        in_sel   = 2'd2;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check("post_data", out_data, 32'h33333333);
        check("post_cnt", 32'(bad_sel_cnt), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Safety net against a hung run.
    initial begin
        #100000;
        $display("FAIL timeout: observed no finish expected finish by 100us");
        $fatal(1, "timeout");
    end

endmodule
